// File: rtl/hd63701_ocu_timer.sv
// HD63701-style free-running counter: output compare, input capture and overflow.
// Register bank with coherent hi/lo access, a single interrupt request and a priority vector.
module hd63701_ocu_timer #(
    parameter logic [15:0] BASE = 16'h0008,
    parameter int          NOC  = 2,
    parameter int          PS   = 0
) (
    input  logic           mcu_clx2,
    input  logic           mcu_rst_n,
    input  logic [15:0]    mcu_ad,
    input  logic           mcu_wr,
    input  logic           mcu_rd,
    input  logic [7:0]     mcu_do,
    input  logic           tin,
    output logic [NOC-1:0] poc,
    output logic           en_timer,
    output logic [7:0]     timerd,
    output logic           irq,
    output logic [3:0]     irqv
);
    localparam logic [3:0] PRE_TC = 4'((1 << PS) - 1);

    logic [15:0]    off;
    int             oc_k;
    logic           reg_hit, oc_hit, wr_en, rd_en;

    logic [3:0]     pre_q, pre_d;
    logic [15:0]    frc_q, frc_d, icr_q, icr_d;
    logic [7:0]     tmp_q, tmp_d, frc_buf_q, frc_buf_d, icr_buf_q, icr_buf_d;
    logic [2:0]     ctrl_q, ctrl_d;          // [2] TOIE, [1] ICIE, [0] IEDG
    logic [3:0]     oce_q, oce_d, olvl_q, olvl_d;
    logic           tof_q, tof_d, icf_q, icf_d;
    logic [NOC-1:0] ocf_q, ocf_d, inh_q, inh_d, poc_q, poc_d;
    logic [15:0]    ocr_q [NOC];
    logic [15:0]    ocr_d [NOC];
    logic [2:0]     tin_q, tin_d;
    logic           frc_new_q, frc_new_d, irq_q, irq_d;
    logic [3:0]     irqv_q, irqv_d;

    logic           tick, frc_load, stat_wr, cap;
    logic [3:0]     ocf4;

    assign off      = mcu_ad - BASE;
    assign oc_k     = int'(off[2:1]);
    assign reg_hit  = (off[15:3] == 13'd0) && (off[2:0] != 3'd7);
    assign oc_hit   = (off[15:3] == 13'd1) && (oc_k < NOC);
    assign en_timer = reg_hit | oc_hit;
    assign wr_en    = mcu_wr & en_timer;
    assign rd_en    = mcu_rd & en_timer;

    assign poc  = poc_q;
    assign irq  = irq_q;
    assign irqv = irqv_q;

    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            pre_q     <= '0;
            frc_q     <= '0;
            icr_q     <= '0;
            tmp_q     <= '0;
            frc_buf_q <= '0;
            icr_buf_q <= '0;
            ctrl_q    <= '0;
            oce_q     <= '0;
            olvl_q    <= '0;
            tof_q     <= 1'b0;
            icf_q     <= 1'b0;
            ocf_q     <= '0;
            inh_q     <= '0;
            poc_q     <= '0;
            for (int k = 0; k < NOC; k++) ocr_q[k] <= 16'hFFFF;
            tin_q     <= '0;
            frc_new_q <= 1'b0;
            irq_q     <= 1'b0;
            irqv_q    <= '0;
        end else begin
            pre_q     <= pre_d;
            frc_q     <= frc_d;
            icr_q     <= icr_d;
            tmp_q     <= tmp_d;
            frc_buf_q <= frc_buf_d;
            icr_buf_q <= icr_buf_d;
            ctrl_q    <= ctrl_d;
            oce_q     <= oce_d;
            olvl_q    <= olvl_d;
            tof_q     <= tof_d;
            icf_q     <= icf_d;
            ocf_q     <= ocf_d;
            inh_q     <= inh_d;
            poc_q     <= poc_d;
            ocr_q     <= ocr_d;
            tin_q     <= tin_d;
            frc_new_q <= frc_new_d;
            irq_q     <= irq_d;
            irqv_q    <= irqv_d;
        end
    end

    always_comb begin
        frc_load = wr_en && reg_hit && (off[2:0] == 3'd3);
        stat_wr  = wr_en && reg_hit && (off[2:0] == 3'd1);
        tick     = 1'b0;
        pre_d    = pre_q + 4'd1;
        if (frc_load) begin
            pre_d = '0;
        end else if (pre_q == PRE_TC) begin
            tick  = 1'b1;
            pre_d = '0;
        end
        frc_d     = frc_load ? {tmp_q, mcu_do} : (tick ? frc_q + 16'd1 : frc_q);
        frc_new_d = frc_load | tick;

        tmp_d = tmp_q;
        if (wr_en && ((reg_hit && off[2:0] == 3'd2) || (oc_hit && !off[0])))
            tmp_d = mcu_do;
        ctrl_d = (wr_en && reg_hit && off[2:0] == 3'd0) ? mcu_do[7:5] : ctrl_q;
        oce_d  = (wr_en && reg_hit && off[2:0] == 3'd4) ? mcu_do[3:0] : oce_q;
        olvl_d = (wr_en && reg_hit && off[2:0] == 3'd4) ? mcu_do[7:4] : olvl_q;
        frc_buf_d = (rd_en && reg_hit && off[2:0] == 3'd2) ? frc_q[7:0] : frc_buf_q;
        icr_buf_d = (rd_en && reg_hit && off[2:0] == 3'd5) ? icr_q[7:0] : icr_buf_q;

        // Edge detect on the second synchroniser stage against its delayed copy.
        tin_d = {tin_q[1:0], tin};
        cap   = ctrl_q[0] ? (tin_q[1] & ~tin_q[2]) : (~tin_q[1] & tin_q[2]);
        icr_d = cap ? frc_q : icr_q;

        // Clears are applied first so a same-cycle set overrides them.
        tof_d = tof_q & ~(stat_wr & mcu_do[7]);
        if (tick && frc_q == 16'hFFFF) tof_d = 1'b1;
        icf_d = icf_q & ~(stat_wr & mcu_do[6]);
        if (cap) icf_d = 1'b1;

        for (int k = 0; k < NOC; k++) begin
            ocr_d[k] = ocr_q[k];
            inh_d[k] = inh_q[k];
            poc_d[k] = poc_q[k];
            ocf_d[k] = ocf_q[k] & ~(stat_wr & mcu_do[k]);
            if (wr_en && oc_hit && oc_k == k) begin
                if (!off[0]) begin
                    inh_d[k] = 1'b1;
                end else begin
                    inh_d[k] = 1'b0;
                    ocr_d[k] = {tmp_q, mcu_do};
                end
            end
            if (frc_new_q && !inh_q[k] && frc_q == ocr_q[k]) begin
                ocf_d[k] = 1'b1;
                poc_d[k] = olvl_q[k];
            end
        end

        // Lowest priority assigned first, so higher-priority sources overwrite.
        irqv_d = 4'd0;
        if (tof_q && ctrl_q[2]) irqv_d = 4'd6;
        for (int k = NOC - 1; k >= 0; k--)
            if (ocf_q[k] && oce_q[k]) irqv_d = 4'(k + 2);
        if (icf_q && ctrl_q[1]) irqv_d = 4'd1;
        irq_d = (irqv_d != 4'd0);
    end

    always_comb begin
        ocf4 = 4'b0000;
        for (int k = 0; k < NOC; k++) ocf4[k] = ocf_q[k];
        timerd = 8'h00;
        if (reg_hit) begin
            case (off[2:0])
                3'd0:    timerd = {ctrl_q, 5'b00000};
                3'd1:    timerd = {tof_q, icf_q, 2'b00, ocf4};
                3'd2:    timerd = frc_q[15:8];
                3'd3:    timerd = frc_buf_q;
                3'd4:    timerd = {olvl_q, oce_q};
                3'd5:    timerd = icr_q[15:8];
                3'd6:    timerd = icr_buf_q;
                default: timerd = 8'h00;
            endcase
        end else if (oc_hit) begin
            for (int k = 0; k < NOC; k++)
                if (oc_k == k) timerd = off[0] ? ocr_q[k][7:0] : ocr_q[k][15:8];
        end
    end
endmodule

// File: tb/tb_hd63701_ocu_timer.sv
// Randomised bench for hd63701_ocu_timer; FRC is modelled as elapsed clocks since the last load.
module tb_hd63701_ocu_timer;
    localparam logic [15:0] BASE = 16'h0008;
    localparam logic [15:0] IDLE = 16'h0100;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] ad = IDLE;
    logic        wr = 1'b0, rd = 1'b0, tin = 1'b0;
    logic [7:0]  dout = 8'h00;
    logic [1:0]  poc, poc2;
    logic        en, en2, irq, irq2;
    logic [7:0]  td, td2;
    logic [3:0]  irqv, irqv2;

    hd63701_ocu_timer #(.BASE(BASE), .NOC(2), .PS(0)) dut (
        .mcu_clx2(clk), .mcu_rst_n(rst_n), .mcu_ad(ad), .mcu_wr(wr), .mcu_rd(rd),
        .mcu_do(dout), .tin(tin), .poc(poc), .en_timer(en), .timerd(td),
        .irq(irq), .irqv(irqv));

    hd63701_ocu_timer #(.BASE(BASE), .NOC(2), .PS(2)) dut2 (
        .mcu_clx2(clk), .mcu_rst_n(rst_n), .mcu_ad(ad), .mcu_wr(wr), .mcu_rd(rd),
        .mcu_do(dout), .tin(tin), .poc(poc2), .en_timer(en2), .timerd(td2),
        .irq(irq2), .irqv(irqv2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0, n_pass = 0;
    logic [15:0] m_base = 16'h0000;
    int          m_cyc0 = 0;
    logic [15:0] m_icr = 16'h0000;

    function automatic logic [15:0] frc_at(input int c);
        return m_base + 16'(c - m_cyc0);
    endfunction

    function automatic logic [15:0] frc2_at(input int c);
        return m_base + 16'((c - m_cyc0) / 4);
    endfunction

    task automatic wr_reg(input int o, input logic [7:0] d);
        @(negedge clk);
        ad = BASE + 16'(o); dout = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; ad = IDLE;
    endtask

    task automatic rd_reg(input int o, output logic [7:0] d, output logic [7:0] d2, output int c);
        @(negedge clk);
        ad = BASE + 16'(o); rd = 1'b1;
        #1 d = td; d2 = td2; c = cyc;
        @(negedge clk);
        rd = 1'b0; ad = IDLE;
    endtask

    task automatic rd_pair(input int o, output logic [15:0] v, output logic [15:0] v2, output int c);
        logic [7:0] h, h2, l, l2;
        int cu;
        rd_reg(o, h, h2, c);
        rd_reg(o + 1, l, l2, cu);
        v = {h, l}; v2 = {h2, l2};
    endtask

    task automatic wr_frc(input logic [15:0] v);
        wr_reg(2, v[15:8]);
        wr_reg(3, v[7:0]);
        m_base = v; m_cyc0 = cyc;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        m_base = 16'h0000; m_cyc0 = cyc;
    endtask

    task automatic test_reset();
        logic [7:0] d, d2;
        logic [15:0] v, v2;
        int c;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({poc, irq, irqv, poc2, irq2, irqv2} !== 14'd0)
            $display("FAIL reset_outputs: got %h expected 0", {poc, irq, irqv, poc2, irq2, irqv2});
        else n_pass++;
        release_reset();
        rd_reg(0, d, d2, c);
        n_checks++;
        if (d !== 8'h00) $display("FAIL reset_ctrl: got %h expected 00", d); else n_pass++;
        rd_reg(1, d, d2, c);
        n_checks++;
        if (d !== 8'h00) $display("FAIL reset_stat: got %h expected 00", d); else n_pass++;
        rd_pair(8, v, v2, c);
        n_checks++;
        if (v !== 16'hFFFF) $display("FAIL reset_ocr0: got %h expected FFFF", v); else n_pass++;
        rd_pair(5, v, v2, c);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL reset_icr: got %h expected 0000", v); else n_pass++;
        rd_pair(2, v, v2, c);
        n_checks++;
        if (v !== frc_at(c)) $display("FAIL reset_frc_ps0: got %h expected %h", v, frc_at(c)); else n_pass++;
        n_checks++;
        if (v2 !== frc2_at(c)) $display("FAIL reset_frc_ps2: got %h expected %h", v2, frc2_at(c)); else n_pass++;
    endtask

    task automatic test_frc_rw();
        logic [15:0] w, v, v2;
        int c;
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            wr_frc(w);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            rd_pair(2, v, v2, c);
            n_checks++;
            if (v !== frc_at(c)) $display("FAIL frc_rw_ps0: got %h expected %h", v, frc_at(c)); else n_pass++;
            n_checks++;
            if (v2 !== frc2_at(c)) $display("FAIL frc_rw_ps2: got %h expected %h", v2, frc2_at(c)); else n_pass++;
        end
    endtask

    task automatic test_compare();
        logic [15:0] ocr;
        logic [7:0] d, d2;
        logic       olvl;
        logic [3:0] v_at;
        int n, match, t_poc, t_irq, c;
        for (int i = 0; i < 4; i++) begin
            ocr  = (i == 0) ? 16'h0010 : 16'($urandom);
            n    = (i == 0) ? 12 : int'($urandom_range(3, 40));
            olvl = (i % 2 == 0);
            wr_reg(4, {3'b000, olvl, 4'b0001});
            wr_frc(ocr ^ 16'h8000);
            wr_reg(8, ocr[15:8]);
            wr_reg(9, ocr[7:0]);
            wr_reg(1, 8'hFF);
            wr_frc(ocr - 16'(n));
            match = m_cyc0 + n;
            t_poc = -1; t_irq = -1; v_at = 4'd0;
            for (int k = 0; k < n + 10; k++) begin
                @(negedge clk);
                if (t_poc < 0 && poc[0] == olvl) t_poc = cyc;
                if (t_irq < 0 && irq) begin t_irq = cyc; v_at = irqv; end
            end
            n_checks++;
            if (t_poc !== match + 1) $display("FAIL oc_poc_time: got %0d expected %0d", t_poc, match + 1); else n_pass++;
            n_checks++;
            if (t_irq !== match + 2) $display("FAIL oc_irq_time: got %0d expected %0d", t_irq, match + 2); else n_pass++;
            n_checks++;
            if (v_at !== 4'd2) $display("FAIL oc_irqv: got %0d expected 2", v_at); else n_pass++;
            rd_reg(1, d, d2, c);
            n_checks++;
            if (d[0] !== 1'b1) $display("FAIL oc_ocf0: got %b expected 1", d[0]); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d, d2;
        logic [3:0] v_at;
        int t_irq, c;
        wr_reg(4, 8'h00);
        wr_reg(0, 8'h80);
        wr_reg(1, 8'hFF);
        wr_frc(16'hFFFE);
        t_irq = -1; v_at = 4'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (t_irq < 0 && irq) begin t_irq = cyc; v_at = irqv; end
        end
        n_checks++;
        if (t_irq !== m_cyc0 + 3) $display("FAIL ovf_irq_time: got %0d expected %0d", t_irq, m_cyc0 + 3); else n_pass++;
        n_checks++;
        if (v_at !== 4'd6) $display("FAIL ovf_irqv: got %0d expected 6", v_at); else n_pass++;
        rd_reg(1, d, d2, c);
        n_checks++;
        if (d[7] !== 1'b1) $display("FAIL ovf_tof_set: got %b expected 1", d[7]); else n_pass++;
        wr_reg(1, 8'h80);
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL ovf_irq_clear: got %b expected 0", irq); else n_pass++;
        rd_reg(1, d, d2, c);
        n_checks++;
        if (d[7] !== 1'b0) $display("FAIL ovf_tof_clear: got %b expected 0", d[7]); else n_pass++;
        // W1C lands on the wrap edge: the set must survive.
        wr_frc(16'hFFFE);
        wr_reg(1, 8'h80);
        rd_reg(1, d, d2, c);
        n_checks++;
        if (d[7] !== 1'b1) $display("FAIL ovf_set_wins: got %b expected 1", d[7]); else n_pass++;
        wr_reg(1, 8'hFF);
        wr_reg(0, 8'h00);
    endtask

    task automatic test_capture();
        logic [15:0] v, v2, exp_new;
        logic [7:0] d, d2;
        int c, cu;
        wr_reg(0, 8'h60);
        wr_reg(4, 8'h01);
        wr_reg(8, 8'h10);
        wr_reg(9, 8'h08);
        wr_reg(1, 8'hFF);
        wr_frc(16'h1000);
        repeat (15) @(negedge clk);
        n_checks++;
        if ({irq, irqv} !== 5'h12) $display("FAIL cap_pre_ocf: got %h expected 12", {irq, irqv}); else n_pass++;
        tin = 1'b1; c = cyc;
        m_icr = frc_at(c + 2);
        repeat (4) @(negedge clk);
        n_checks++;
        if (irqv !== 4'd1) $display("FAIL cap_irqv_prio: got %0d expected 1", irqv); else n_pass++;
        rd_pair(5, v, v2, cu);
        n_checks++;
        if (v !== m_icr) $display("FAIL cap_rise: got %h expected %h", v, m_icr); else n_pass++;
        @(negedge clk);
        tin = 1'b0;
        repeat (4) @(negedge clk);
        rd_pair(5, v, v2, cu);
        n_checks++;
        if (v !== m_icr) $display("FAIL cap_wrong_edge: got %h expected %h", v, m_icr); else n_pass++;
        @(negedge clk);
        tin = 1'b1; c = cyc;
        exp_new = frc_at(c + 2);
        rd_reg(5, d, d2, cu);
        repeat (2) @(negedge clk);
        rd_reg(6, d, d2, cu);
        n_checks++;
        if (d !== m_icr[7:0]) $display("FAIL cap_coherent_lo: got %h expected %h", d, m_icr[7:0]); else n_pass++;
        m_icr = exp_new;
        rd_pair(5, v, v2, cu);
        n_checks++;
        if (v !== m_icr) $display("FAIL cap_new: got %h expected %h", v, m_icr); else n_pass++;
        wr_reg(0, 8'h40);
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(1, 6)) @(negedge clk);
            tin = 1'b0; c = cyc;
            m_icr = frc_at(c + 2);
            repeat (4) @(negedge clk);
            rd_pair(5, v, v2, cu);
            n_checks++;
            if (v !== m_icr) $display("FAIL cap_fall: got %h expected %h", v, m_icr); else n_pass++;
            @(negedge clk);
            tin = 1'b1;
            repeat (4) @(negedge clk);
            rd_pair(5, v, v2, cu);
            n_checks++;
            if (v !== m_icr) $display("FAIL cap_fall_ignore_rise: got %h expected %h", v, m_icr); else n_pass++;
        end
        wr_reg(0, 8'h00);
    endtask

    task automatic test_inhibit();
        logic [15:0] tgt, new_ocr;
        logic [7:0] d, d2;
        int c, match, t_poc;
        wr_reg(4, 8'h11);
        wr_frc(16'h6000);
        wr_reg(8, 8'h20);
        wr_reg(9, 8'h40);
        wr_reg(1, 8'hFF);
        wr_frc(16'h2030);
        wr_reg(8, 8'h20);
        repeat (40) @(negedge clk);
        n_checks++;
        if (poc[0] !== 1'b0) $display("FAIL inh_poc: got %b expected 0", poc[0]); else n_pass++;
        rd_reg(1, d, d2, c);
        n_checks++;
        if (d[0] !== 1'b0) $display("FAIL inh_ocf0: got %b expected 0", d[0]); else n_pass++;
        tgt = frc_at(cyc) + 16'd20;
        new_ocr = {8'h20, tgt[7:0]};
        match = m_cyc0 + int'(new_ocr - m_base);
        wr_reg(9, tgt[7:0]);
        t_poc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (t_poc < 0 && poc[0] == 1'b1) t_poc = cyc;
        end
        n_checks++;
        if (t_poc !== match + 1) $display("FAIL inh_resume: got %0d expected %0d", t_poc, match + 1); else n_pass++;
    endtask

    task automatic test_decode();
        logic exp_en;
        logic [15:0] v, v2;
        int c;
        for (int o = -1; o < 16; o++) begin
            @(negedge clk);
            ad = BASE + 16'(o);
            #1;
            exp_en = (o >= 0 && o <= 6) || (o >= 8 && o < 12);
            n_checks++;
            if (en !== exp_en) $display("FAIL decode_en_%0d: got %b expected %b", o, en, exp_en); else n_pass++;
            if (!exp_en) begin
                n_checks++;
                if (td !== 8'h00) $display("FAIL decode_rd0_%0d: got %h expected 00", o, td); else n_pass++;
            end
        end
        ad = IDLE;
        wr_reg(5, 8'hA5);
        wr_reg(6, 8'h5A);
        rd_pair(5, v, v2, c);
        n_checks++;
        if (v !== m_icr) $display("FAIL icr_readonly: got %h expected %h", v, m_icr); else n_pass++;
    endtask

    task automatic test_ps2_reset();
        logic [15:0] v, v2;
        int c;
        wr_reg(0, 8'h80);
        wr_reg(1, 8'hFF);
        wr_frc(16'hFFFC);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        rd_pair(2, v, v2, c);
        n_checks++;
        if (v2 !== frc2_at(c)) $display("FAIL ps2_frc: got %h expected %h", v2, frc2_at(c)); else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++;
        if ({irq, irq2} !== 2'b11) $display("FAIL ps2_pre_irq: got %b expected 11", {irq, irq2}); else n_pass++;
        @(negedge clk);
        ad = BASE + 16'd2;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({poc, irq, irqv, poc2, irq2, irqv2} !== 14'd0)
            $display("FAIL async_reset_outputs: got %h expected 0", {poc, irq, irqv, poc2, irq2, irqv2});
        else n_pass++;
        n_checks++;
        if ({td, td2} !== 16'h0000) $display("FAIL async_reset_frc: got %h expected 0000", {td, td2}); else n_pass++;
        ad = IDLE;
        repeat (2) @(negedge clk);
        release_reset();
        repeat ($urandom_range(0, 5)) @(negedge clk);
        rd_pair(2, v, v2, c);
        n_checks++;
        if (v2 !== frc2_at(c)) $display("FAIL ps2_after_reset: got %h expected %h", v2, frc2_at(c)); else n_pass++;
        n_checks++;
        if (v !== frc_at(c)) $display("FAIL ps0_after_reset: got %h expected %h", v, frc_at(c)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frc_rw();
        test_compare();
        test_overflow();
        test_capture();
        test_inhibit();
        test_decode();
        test_ps2_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hd63701_ocu_timer.md
HD63701_OCU_TIMER -- requirements
Module: hd63701_ocu_timer

Interface
REQ-001 SHALL have parameter BASE, default 16'h0008, bus address of register offset 0.
REQ-002 SHALL have parameter NOC, default 2, number of output-compare channels, legal 1..4.
REQ-003 SHALL have parameter PS, default 0, prescale exponent; counter ticks every 2**PS clocks, legal 0..4.
REQ-004 SHALL have port mcu_clx2  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port mcu_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port mcu_ad  in  16  bus address.
REQ-007 SHALL have port mcu_wr  in  1  write strobe, one cycle per access.
REQ-008 SHALL have port mcu_rd  in  1  read strobe, one cycle per access.
REQ-009 SHALL have port mcu_do  in  8  write data.
REQ-010 SHALL have port tin  in  1  asynchronous input-capture pin.
REQ-011 SHALL have port poc  out  NOC  compare output pins.
REQ-012 SHALL have port en_timer  out  1  high when mcu_ad hits a decoded register.
REQ-013 SHALL have port timerd  out  8  combinational read data, 0 when not decoded.
REQ-014 SHALL have port irq  out  1  interrupt request.
REQ-015 SHALL have port irqv  out  4  vector index of highest-priority pending source.

Function
REQ-016 Register map, offset from BASE: +0 CTRL [7]TOIE [6]ICIE [5]IEDG (1 rising, 0 falling), rest read 0.
REQ-017 +1 STAT [7]TOF [6]ICF [3:0]OCF[k]; write-1-to-clear; unused bits read 0.
REQ-018 +2/+3 FRC hi/lo; +4 OCE[3:0] in [3:0], OLVL[3:0] in [7:4]; +5/+6 ICR hi/lo, read-only.
REQ-019 +8+2k/+9+2k OCR k hi/lo for k<NOC; offsets for k>=NOC not decoded.
REQ-020 Prescaler: 2**PS clocks per tick; PS=0 ticks every clock; FRC 16 bits, increments by 1 per tick.
REQ-021 FRC wrap FFFF->0000 on a tick SHALL set TOF same edge.
REQ-022 Write FRC hi stores byte in temp; write FRC lo loads FRC={temp,data} and clears prescaler; no tick that cycle.
REQ-023 Read FRC hi (mcu_rd) latches FRC[7:0] into read buffer; read FRC lo returns buffer, so hi/lo pair is coherent.
REQ-024 Compare: after each tick or FRC load, if FRC==OCR k then OCF[k] set and poc[k]<=OLVL[k] next edge; evaluation is per new FRC value, once.
REQ-025 Write OCR k hi inhibits compare on channel k until OCR k lo written; OCR updates only at lo write, from {temp,data}.
REQ-026 tin synchronised by two flops; selected edge on synchronised signal captures FRC into ICR and sets ICF; latency 3 clocks pin-to-ICR.
REQ-027 Read ICR hi latches ICR[7:0] into buffer; capture between hi and lo reads SHALL NOT alter the lo value returned.
REQ-028 Flag set and W1C same cycle: set wins.
REQ-029 irq = (TOF&TOIE)|(ICF&ICIE)|OR_k(OCF[k]&OCE[k]), registered, one-cycle latency from flag.
REQ-030 irqv priority ICF=1, OCF0..3=2..5, TOF=6; 0 when irq low.
REQ-031 Reads SHALL NOT change flags; read data independent of mcu_rd except buffer latching.
REQ-032 Writes to read-only or undecoded offsets ignored.

Reset
REQ-033 On mcu_rst_n low: FRC=0000, prescaler 0, OCR all FFFF, ICR 0000, CTRL 00, OCE/OLVL 0, flags 0, temps/buffers 0, poc all 0, irq 0, irqv 0.
REQ-034 Reset mid-operation aborts pending hi/lo sequences; inhibit from REQ-025 cleared.
REQ-035 First tick after release occurs 2**PS clocks after first rising edge with mcu_rst_n high.

Verification
REQ-036 PS=0: write OCR0=0010, OCE0=1, OLVL0=1 -> OCF0 set and poc[0]=1 when FRC reaches 0010; irq=1, irqv=2 one clock later.
REQ-037 Write FRC=FFFE, TOIE=1 -> after 2 ticks FRC=0000, TOF=1, irq=1, irqv=6; write STAT=80 -> TOF=0, irq=0.
REQ-038 IEDG=1, ICIE=1, FRC free-running; rising tin -> ICR=FRC value 2 clocks after pin edge, ICF=1, irqv=1 overriding pending OCF.
REQ-039 Read ICR hi, capture new value, read ICR lo -> lo byte from pre-capture value.
REQ-040 Write OCR0 hi only while FRC passes matching value -> no OCF0; write lo -> compare resumes.
REQ-041 PS=2: FRC increments every 4 clocks; assert mcu_rst_n low mid-count -> all outputs to reset values immediately.
